// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO: buffers words and sends them as
// start/data/parity/stop frames on TXD, back-to-back while data is queued.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 2585,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_en,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          TXD
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_PER_BIT);

  if (CLK_PER_BIT < 2) begin : g_bad_cpb
    $error("CLK_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q;
  logic                 full_q;
  logic [LW-1:0]        level_q, level_d;
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic                 wr;
  logic                 pop;
  logic                 wrap;
  logic [DATA_BITS-1:0] head;

  assign wr      = wr_en && !full_q;
  assign wrap    = cnt_q == CW'(CLK_PER_BIT - 1);
  assign head    = mem[rptr_q];
  assign level_d = level_q + LW'(wr) - LW'(pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (level_q != '0) pop = 1'b1;
      end
      START: begin
        if (wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? PAR : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (wrap) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (wrap) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            if (level_q != '0) pop = 1'b1;
            else state_d = IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Pop overrides: load the next word and restart at the start bit
    if (pop) begin
      state_d = START;
      cnt_d   = '0;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
    end
  end

  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      PAR:     txd_d = par_q;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      level_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= (state_q != IDLE) || (level_q != '0);
      full_q  <= level_d == LW'(FIFO_DEPTH);
      level_q <= level_d;
      wptr_q  <= wptr_q + AW'(wr);
      rptr_q  <= rptr_q + AW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr_q] <= wr_data;
  end

  assign full  = full_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign TXD   = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations share one clock; a frame
// receiver pops expected frames from a scoreboard queue.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0][7:0] wd;
  logic [3:0]      we;
  logic [3:0]      fl;
  logic [3:0][2:0] lv;
  logic [3:0]      bz;
  logic [3:0]      txd;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int last_w;
  int first_fall;
  logic [15:0] fb0;

  int db_c [4] = '{8, 8, 8, 7};
  int pr_c [4] = '{0, 1, 2, 0};
  int sb_c [4] = '{1, 1, 1, 2};

  typedef struct {
    int          nb;
    logic [15:0] bits;
  } frm_t;

  frm_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .CLK(clk), .RST_N(rst_n), .wr_data(wd[0]), .wr_en(we[0]),
    .full(fl[0]), .level(lv[0]), .busy(bz[0]), .TXD(txd[0]));

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .CLK(clk), .RST_N(rst_n), .wr_data(wd[1]), .wr_en(we[1]),
    .full(fl[1]), .level(lv[1]), .busy(bz[1]), .TXD(txd[1]));

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .CLK(clk), .RST_N(rst_n), .wr_data(wd[2]), .wr_en(we[2]),
    .full(fl[2]), .level(lv[2]), .busy(bz[2]), .TXD(txd[2]));

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .CLK(clk), .RST_N(rst_n), .wr_data(wd[3][6:0]), .wr_en(we[3]),
    .full(fl[3]), .level(lv[3]), .busy(bz[3]), .TXD(txd[3]));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nbits(int i);
    return 1 + db_c[i] + ((pr_c[i] != 0) ? 1 : 0) + sb_c[i];
  endfunction

  function automatic frm_t mkf(int i, logic [7:0] d);
    frm_t f;
    logic x;
    int   p;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    x = 1'b0;
    for (int k = 0; k < db_c[i]; k++) begin
      f.bits[1+k] = d[k];
      x ^= d[k];
    end
    p = 1 + db_c[i];
    if (pr_c[i] == 1) f.bits[p] = ~x;
    else if (pr_c[i] == 2) f.bits[p] = x;
    f.nb = nbits(i);
    return f;
  endfunction

  task automatic push(input int i, input logic [7:0] d, input bit acc);
    wd[i] = d;
    we[i] = 1'b1;
    if (acc) sb.push_back(mkf(i, d));
    @(posedge clk);
    #1;
    last_w = cyc;
    we[i] = 1'b0;
  endtask

  task automatic rx_frame(input int i, output logic [15:0] b,
                          output int fall);
    int n;
    n    = 0;
    b    = '1;
    fall = -1;
    while (txd[i] !== 1'b0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (txd[i] !== 1'b0) begin
      check("rx_timeout", 32'd1, 32'd0);
      return;
    end
    fall = cyc;
    repeat (CPB / 2) @(posedge clk);
    #1;
    b[0] = txd[i];
    for (int k = 1; k < nbits(i); k++) begin
      repeat (CPB) @(posedge clk);
      #1;
      b[k] = txd[i];
    end
  endtask

  task automatic run_rx(input int i, input int nf);
    logic [15:0] b;
    int f, pf, pn;
    frm_t e;
    pf = 0;
    pn = 0;
    for (int j = 0; j < nf; j++) begin
      rx_frame(i, b, f);
      if (f < 0) return;
      if (j == 0) begin
        first_fall = f;
        fb0 = b;
      end else begin
        check("gap", f - pf, CPB * pn);
      end
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("frame", {16'h0, b}, {16'h0, e.bits});
      end
      pf = f;
      pn = nbits(i);
    end
  endtask

  task automatic quiet(input int i, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (txd[i] !== 1'b1) lows++;
    end
    check("quiet", lows, 0);
    check("idle_busy", bz[i], 0);
    check("idle_lvl", lv[i], 0);
  endtask

  int lvl_e [6] = '{1, 1, 2, 3, 4, 4};
  int full_e [6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    we = '0;
    wd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd[0], 1);
    check("rst_full", fl[0], 0);
    check("rst_lvl", lv[0], 0);
    check("rst_busy", bz[0], 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    fork
      push(0, 8'hA5, 1'b1);
      run_rx(0, 1);
    join
    check("lat", first_fall - last_w, 2);
    check("a5_line", {22'h0, fb0[9:0]}, {22'h0, 10'b1101001010});
    @(posedge clk);
    #1;
    check("busy_last", bz[0], 1);
    @(posedge clk);
    #1;
    check("busy_clr", bz[0], 0);
    check("txd_idle", txd[0], 1);

    fork
      begin
        push(0, 8'h00, 1'b1);
        check("lvl_a", lv[0], 1);
        push(0, 8'hFF, 1'b1);
        check("lvl_b", lv[0], 1);
      end
      run_rx(0, 2);
    join
    check("lvl_c", lv[0], 0);
    quiet(0, 8);

    fork
      begin
        for (int k = 0; k < 6; k++) begin
          push(0, 8'(8'h11 * (k + 1)), k < 5);
          check("fill_lvl", lv[0], lvl_e[k]);
          check("fill_full", fl[0], full_e[k]);
        end
      end
      run_rx(0, 5);
    join
    quiet(0, 60);

    fork
      begin
        push(1, 8'h03, 1'b1);
        push(1, 8'h07, 1'b1);
      end
      run_rx(1, 2);
    join
    check("par_odd", fb0[9], 1);
    fork
      begin
        push(2, 8'h03, 1'b1);
        push(2, 8'h07, 1'b1);
      end
      run_rx(2, 2);
    join
    check("par_even", fb0[9], 0);

    fork
      begin
        push(3, 8'h41, 1'b1);
        push(3, 8'h2A, 1'b1);
      end
      run_rx(3, 2);
    join
    check("stop2", fb0[9:8], 2'b11);
    quiet(3, 12);

    push(0, 8'h55, 1'b0);
    push(0, 8'h66, 1'b0);
    push(0, 8'h77, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("pre_lvl", lv[0], 2);
    check("pre_txd", txd[0], 0);
    rst_n = 1'b0;
    #1;
    check("arst_txd", txd[0], 1);
    check("arst_lvl", lv[0], 0);
    check("arst_busy", bz[0], 0);
    check("arst_full", fl[0], 0);
    #10;
    rst_n = 1'b1;
    quiet(0, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
